// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered ALU: three carry-chain arithmetic ops and five bitwise ops
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             c_out,
    output logic [WIDTH-1:0] sum,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in
);

    logic [WIDTH:0]   res;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   na_ext;
    logic [WIDTH:0]   nb_ext;
    logic [WIDTH:0]   ci_ext;
    logic [WIDTH:0]   nci_ext;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_d;
    logic             c_out_q;

    // Inverted operands are WIDTH-bit complements, zero-extended before the add,
    // so the carry out of bit WIDTH-1 lands in bit WIDTH as a no-borrow flag.
    always_comb begin
        a_ext   = {1'b0, a};
        b_ext   = {1'b0, b};
        na_ext  = {1'b0, ~a};
        nb_ext  = {1'b0, ~b};
        ci_ext  = {{WIDTH{1'b0}}, c_in};
        nci_ext = {{WIDTH{1'b0}}, ~c_in};
        res     = '0;
        case (oper)
            3'd0:    res = a_ext + b_ext + ci_ext;
            3'd1:    res = a_ext + nb_ext + ci_ext;
            3'd2:    res = b_ext + na_ext + nci_ext;
            3'd3:    res = {1'b0, a | b};
            3'd4:    res = {1'b0, a & b};
            3'd5:    res = {1'b0, (~a) & b};
            3'd6:    res = {1'b0, a ^ b};
            default: res = {1'b0, ~(a ^ b)};
        endcase
    end

    always_comb begin
        sum_d   = res[WIDTH-1:0];
        c_out_d = res[WIDTH];
        if (rst) begin
            sum_d   = '0;
            c_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: reference model plus hand-computed vectors
module tb_alu;

    logic       clk;
    logic       rst;
    logic       c_out;
    logic [7:0] sum;
    logic [2:0] oper;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;

    int total;
    int bad;

    logic [8:0] m_res;
    logic       m_valid;

    alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .c_out (c_out),
        .sum   (sum),
        .oper  (oper),
        .a     (a),
        .b     (b),
        .c_in  (c_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model(input int op, input int aa, input int bb, input int ci);
        int r;
        case (op)
            0:       r = aa + bb + ci;
            1:       r = aa + (255 - bb) + ci;
            2:       r = bb + (255 - aa) + (1 - ci);
            3:       r = aa | bb;
            4:       r = aa & bb;
            5:       r = (255 - aa) & bb;
            6:       r = aa ^ bb;
            default: r = 255 - (aa ^ bb);
        endcase
        return 9'(r % 512);
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual={c_out,sum}=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_res   = 9'h000;
            m_valid = 1'b1;
        end else begin
            m_res = model(int'(oper), int'(a), int'(b), int'(c_in));
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) chk("scoreboard", {c_out, sum}, m_res);
    end

    task automatic drive(input logic r, input logic [2:0] op, input logic [7:0] aa,
                         input logic [7:0] bb, input logic ci);
        @(negedge clk);
        rst  = r;
        oper = op;
        a    = aa;
        b    = bb;
        c_in = ci;
    endtask

    task automatic vec(input string name, input logic [2:0] op, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ci, input logic [8:0] exp);
        drive(1'b0, op, aa, bb, ci);
        @(posedge clk);
        #2;
        chk(name, {c_out, sum}, exp);
        chk({name, "_model"}, m_res, exp);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_valid = 1'b0;
        m_res   = '0;
        rst     = 1'b1;
        oper    = 3'd0;
        a       = 8'hFF;
        b       = 8'hFF;
        c_in    = 1'b1;

        @(posedge clk);
        #2;
        chk("reset", {c_out, sum}, 9'h000);

        vec("add_c0",  3'd0, 8'hD2, 8'hB6, 1'b0, 9'h188);
        vec("add_c1",  3'd0, 8'hD2, 8'hB6, 1'b1, 9'h189);
        vec("subab_c0", 3'd1, 8'hD2, 8'hB6, 1'b0, 9'h11B);
        vec("subab_c1", 3'd1, 8'hD2, 8'hB6, 1'b1, 9'h11C);
        vec("subba_c0", 3'd2, 8'hD2, 8'hB6, 1'b0, 9'h0E4);
        vec("subba_c1", 3'd2, 8'hD2, 8'hB6, 1'b1, 9'h0E3);
        for (int ci = 0; ci < 2; ci++) begin
            vec("or",   3'd3, 8'hD2, 8'hB6, 1'(ci), 9'h0F6);
            vec("and",  3'd4, 8'hD2, 8'hB6, 1'(ci), 9'h092);
            vec("andn", 3'd5, 8'hD2, 8'hB6, 1'(ci), 9'h024);
            vec("xor",  3'd6, 8'hD2, 8'hB6, 1'(ci), 9'h064);
            vec("xnor", 3'd7, 8'hD2, 8'hB6, 1'(ci), 9'h09B);
        end
        vec("wrap_add", 3'd0, 8'hFF, 8'h00, 1'b1, 9'h100);
        vec("wrap_sub", 3'd1, 8'h00, 8'h01, 1'b1, 9'h0FF);

        // Reset mid-stream beats a live add, then the next edge resumes normally.
        vec("run_add", 3'd0, 8'hD2, 8'hB6, 1'b0, 9'h188);
        drive(1'b1, 3'd0, 8'hD2, 8'hB6, 1'b0);
        @(posedge clk);
        #2;
        chk("rst_mid", {c_out, sum}, 9'h000);
        vec("after_rst", 3'd0, 8'hD2, 8'hB6, 1'b0, 9'h188);

        // Inputs changed between edges must not reach the outputs.
        @(posedge clk);
        #3;
        a = 8'h01;
        b = 8'h01;
        #1;
        chk("hold", {c_out, sum}, 9'h188);

        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; all values below assume WIDTH=8.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 oper  input  3  operation select.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 c_in  input  1  carry/borrow input.
REQ-009 c_out  output  1  registered carry-out.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 The port order shall be clk, rst, c_out, sum, oper, a, b, c_in.

Function
REQ-012 Each rising clk edge with rst=0 shall register {c_out, sum} = R(oper, a, b, c_in), where R is a WIDTH+1-bit result.
- Latency: exactly 1 cycle.
- Every cycle is a new operation; there is no handshake or stall.
REQ-013 oper=0 (add): R = a + b + c_in.
REQ-014 oper=1 (subtract A-B): R = a + ~b + c_in.
- c_in=1 gives the true difference a-b.
- c_out=1 means no borrow.
REQ-015 oper=2 (subtract B-A): R = b + ~a + ~c_in.
- c_in=0 gives b-a.
- c_in=1 gives b-a-1.
REQ-016 oper=3: R = {0, a|b}.
REQ-017 oper=4: R = {0, a&b}.
REQ-018 oper=5: R = {0, (~a)&b}.
REQ-019 oper=6: R = {0, a^b}.
REQ-020 oper=7: R = {0, ~(a^b)}.
REQ-021 Arithmetic rules for opers 0-2:
- Evaluated modulo 2^(WIDTH+1).
- sum = low WIDTH bits; c_out = bit WIDTH.
- Overflow wraps silently.
REQ-022 c_in shall be ignored for opers 3-7, and c_out shall be 0 for those opers.
REQ-023 Outputs shall hold between edges; input changes between edges shall have no effect until the next edge.
REQ-024 An X/Z-free oper shall always select exactly one of the eight functions; there are no illegal codes.

Reset
REQ-025 On a rising edge with rst=1: sum=0 and c_out=0, regardless of other inputs.
REQ-026 rst takes priority over any operation presented in the same cycle.
REQ-027 The first edge with rst=0 shall produce the result of the inputs present at that edge.
REQ-028 Outputs are undefined before the first reset edge.

Verification
(a=0xD2, b=0xB6 unless stated)
REQ-029 Add, oper=0:
- c_in=0 -> c_out=1, sum=0x88.
- c_in=1 -> c_out=1, sum=0x89.
REQ-030 Subtract A-B, oper=1:
- c_in=0 -> c_out=1, sum=0x1B.
- c_in=1 -> c_out=1, sum=0x1C.
REQ-031 Subtract B-A, oper=2:
- c_in=0 -> c_out=0, sum=0xE4.
- c_in=1 -> c_out=0, sum=0xE3.
REQ-032 Logic, opers 3..7 with c_in=0 and again with c_in=1 -> c_out=0 and sum as below:
- oper=3 -> 0xF6.
- oper=4 -> 0x92.
- oper=5 -> 0x24.
- oper=6 -> 0x64.
- oper=7 -> 0x9B.
REQ-033 Wrap-around:
- a=0xFF, b=0x00, c_in=1, oper=0 -> c_out=1, sum=0x00.
- a=0x00, b=0x01, c_in=1, oper=1 -> c_out=0, sum=0xFF.
REQ-034 Reset during operation: run oper=0 continuously, assert rst for one cycle -> that edge gives sum=0, c_out=0; the next edge gives 0x88, c_out=1.
